switch_stm_demux: RTL and testbench

//  Registered, handshaked 1-to-N demultiplexer: routes each input word to the output lane chosen
//  by a sel field sent with it; sel values without a lane are consumed and dropped, not stalled.
//  Fan-out counterpart of the sel-driven output multiplexers. Sits between one stream producer
//  and N independent consumers.

---
 rtl/switch_stm_pkg.sv | 16 +
 rtl/switch_stm_demux_if.sv | 30 +++
 rtl/hs_reg_slice.sv | 31 +++
 rtl/switch_stm_demux.sv | 76 +++++++
 tb/tb_switch_stm_demux.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_stm_pkg.sv
// Shared definitions for the sel-driven stream switch blocks.
// Lane indices match those used by the sel-driven output multiplexers.
package switch_stm_pkg;

    localparam int SEL_WIDTH = 3;

    localparam int LANE_A = 0;
    localparam int LANE_B = 1;
    localparam int LANE_C = 2;

    // A sel value only addresses a lane when it is below the lane count.
    function automatic logic lane_valid(input int unsigned sel, input int unsigned n_out);
        return sel < n_out;
    endfunction

endpackage

// File: rtl/switch_stm_demux_if.sv
// Stream bus of the 1-to-N demux: one sel-tagged input stream, N handshaked output lanes.
// master = producer/consumer side, slave = demux side.
interface switch_stm_demux_if
    import switch_stm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_OUT      = 3,
    parameter int SEL_WIDTH  = switch_stm_pkg::SEL_WIDTH,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0]       din_data;
    logic [SEL_WIDTH-1:0]        din_sel;
    logic                        din_vld;
    logic                        din_rd;
    logic [N_OUT*DATA_WIDTH-1:0] dout_data;
    logic [N_OUT-1:0]            dout_vld;
    logic [N_OUT-1:0]            dout_rd;
    logic [CNT_WIDTH-1:0]        drop_cnt;

    modport master (
        output din_data, din_sel, din_vld, dout_rd,
        input  din_rd, dout_data, dout_vld, drop_cnt
    );

    modport slave (
        input  din_data, din_sel, din_vld, dout_rd,
        output din_rd, dout_data, dout_vld, drop_cnt
    );

endinterface

// File: rtl/hs_reg_slice.sv
// One-entry valid/ready register slice with simultaneous drain and load.
// Latency: 1 cycle from load to vld. Backpressure: free = !vld | rd; caller loads only when free.
module hs_reg_slice #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  rd,
    output logic                  vld,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  free
);

    assign free = !vld || rd;

    // Load wins over drain so a same-cycle drain+load keeps the lane full with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            data <= load_data;
        end else if (rd) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/switch_stm_demux.sv
// Registered 1-to-N demux: routes each word to lane din_sel, drops and counts sel >= N_OUT.
// Latency: 1 cycle per lane. Backpressure: din_rd follows only the addressed lane; drops never stall.
module switch_stm_demux
    import switch_stm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_OUT      = 3,
    parameter int SEL_WIDTH  = switch_stm_pkg::SEL_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    switch_stm_demux_if.slave  bus
);

    logic [N_OUT-1:0]          lane_free;
    logic [N_OUT-1:0]          lane_load;
    logic [N_OUT-1:0]          lane_vld;
    logic [DATA_WIDTH-1:0]     lane_data [N_OUT];
    logic [2**SEL_WIDTH-1:0]   free_pad;
    logic [N_OUT*DATA_WIDTH-1:0] dout_data_w;
    logic [CNT_WIDTH-1:0]      drop_cnt_q;
    logic                      sel_ok;
    logic                      accept;

    assign sel_ok = lane_valid(int'(bus.din_sel), N_OUT);

    // Unmapped sel codes read as always-free so dropped words are consumed immediately.
    always_comb begin
        free_pad = '1;
        for (int i = 0; i < N_OUT; i++) begin
            free_pad[i] = lane_free[i];
        end
    end

    assign bus.din_rd = rst_n && free_pad[bus.din_sel];
    assign accept     = bus.din_vld && bus.din_rd;

    for (genvar i = 0; i < N_OUT; i++) begin : g_lane
        assign lane_load[i] = accept && sel_ok && (bus.din_sel == SEL_WIDTH'(i));

        hs_reg_slice #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (lane_load[i]),
            .load_data (bus.din_data),
            .rd        (bus.dout_rd[i]),
            .vld       (lane_vld[i]),
            .data      (lane_data[i]),
            .free      (lane_free[i])
        );
    end

    always_comb begin
        dout_data_w = '0;
        for (int i = 0; i < N_OUT; i++) begin
            dout_data_w[i*DATA_WIDTH +: DATA_WIDTH] = lane_data[i];
        end
    end

    assign bus.dout_data = dout_data_w;
    assign bus.dout_vld  = lane_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (accept && !sel_ok && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_switch_stm_demux.sv
// Scoreboard bench for switch_stm_demux: a lane-occupancy model predicts din_rd/dout_vld/drop_cnt,
// per-lane expected-data queues are popped by an independent output monitor.
module tb_switch_stm_demux;
    import switch_stm_pkg::*;

    localparam int DW = 8;
    localparam int NO = 3;
    localparam int SW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    switch_stm_demux_if #(.DATA_WIDTH(DW), .N_OUT(NO), .SEL_WIDTH(SW), .CNT_WIDTH(16)) bus ();
    switch_stm_demux_if #(.DATA_WIDTH(DW), .N_OUT(NO), .SEL_WIDTH(SW), .CNT_WIDTH(2))  bus2 ();

    assign bus2.din_data = bus.din_data;
    assign bus2.din_sel  = bus.din_sel;
    assign bus2.din_vld  = bus.din_vld;
    assign bus2.dout_rd  = bus.dout_rd;

    switch_stm_demux #(.DATA_WIDTH(DW), .N_OUT(NO), .SEL_WIDTH(SW), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    switch_stm_demux #(.DATA_WIDTH(DW), .N_OUT(NO), .SEL_WIDTH(SW), .CNT_WIDTH(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q [NO][$];
    bit            full_m [NO];
    int            drops_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NO; i++) begin
            full_m[i] = 1'b0;
            exp_q[i].delete();
        end
        drops_m = 0;
    endtask

    // Input-side model: predicts handshake, occupancy and drop count, pushes accepted words.
    always @(negedge clk) begin : in_mon
        int         s;
        logic       exp_rd;
        logic [2:0] exp_vld;
        if (rst_n) begin
            s      = int'(bus.din_sel);
            exp_rd = (s < NO) ? (!full_m[s] || bus.dout_rd[s]) : 1'b1;
            for (int i = 0; i < NO; i++) exp_vld[i] = full_m[i];
            chk("din_rd", 64'(bus.din_rd), 64'(exp_rd));
            chk("dout_vld", 64'(bus.dout_vld), 64'(exp_vld));
            chk("drop_cnt", 64'(bus.drop_cnt), 64'(drops_m));
            chk("drop_cnt_sat", 64'(bus2.drop_cnt), 64'((drops_m > 3) ? 3 : drops_m));
            for (int i = 0; i < NO; i++) begin
                if (full_m[i] && bus.dout_rd[i]) full_m[i] = 1'b0;
            end
            if (bus.din_vld && exp_rd) begin
                if (s < NO) begin
                    exp_q[s].push_back(bus.din_data);
                    full_m[s] = 1'b1;
                end else begin
                    drops_m++;
                end
            end
        end
    end

    // Output monitor: pops on every lane handshake and enforces the hold rule.
    bit            held   [NO];
    logic [DW-1:0] held_d [NO];
    always @(negedge clk) begin : out_mon
        logic [DW-1:0] d;
        for (int i = 0; i < NO; i++) begin
            if (!rst_n) begin
                held[i] = 1'b0;
            end else begin
                d = bus.dout_data[i*DW +: DW];
                if (bus.dout_vld[i]) begin
                    if (held[i]) chk($sformatf("hold_lane%0d", i), 64'(d), 64'(held_d[i]));
                    if (bus.dout_rd[i]) begin
                        if (exp_q[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL lane%0d_unexpected: got 0x%0h, expected no word at t=%0t", i, d, $time);
                        end else begin
                            chk($sformatf("lane%0d_data", i), 64'(d), 64'(exp_q[i].pop_front()));
                        end
                    end
                end
                held[i]   = bus.dout_vld[i] && !bus.dout_rd[i];
                held_d[i] = d;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [DW-1:0] d);
        int n;
        bus.din_sel  = SW'(s);
        bus.din_data = d;
        bus.din_vld  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.din_rd) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: sel=%0d not accepted, expected acceptance within 100 cycles", s);
                break;
            end
        end
        tick();
        bus.din_vld = 1'b0;
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [DW-1:0] route_dat [3];

    initial begin
        bus.din_vld  = 1'b0;
        bus.din_sel  = '0;
        bus.din_data = '0;
        bus.dout_rd  = '0;
        clear_model();
        repeat (3) tick();
        chk("reset_vld", 64'(bus.dout_vld), 64'd0);
        chk("reset_cnt", 64'(bus.drop_cnt), 64'd0);
        chk("reset_rd", 64'(bus.din_rd), 64'd0);
        rst_n = 1'b1;
        tick();

        // Reset mid-transfer with lane 1 full and a blocked word pending.
        send(LANE_B, 8'h3C);
        send(5, 8'h00);
        bus.din_sel  = SW'(LANE_B);
        bus.din_data = 8'h77;
        bus.din_vld  = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vld", 64'(bus.dout_vld), 64'd0);
        chk("async_rst_cnt", 64'(bus.drop_cnt), 64'd0);
        chk("async_rst_rd", 64'(bus.din_rd), 64'd0);
        chk("async_rst_data", 64'(bus.dout_data), 64'd0);
        clear_model();
        bus.din_vld = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bus.dout_rd = 3'b111;
        tick();
        send(LANE_B, 8'hA5);
        @(negedge clk);
        chk("post_rst_vld", 64'(bus.dout_vld), 64'h2);
        chk("post_rst_data", 64'(bus.dout_data[LANE_B*DW +: DW]), 64'hA5);
        tick();

        // Routing, one lane at a time.
        route_dat[0] = 8'h11;
        route_dat[1] = 8'h22;
        route_dat[2] = 8'h33;
        for (int k = 0; k < 3; k++) begin
            send(k, route_dat[k]);
            @(negedge clk);
            chk("route_onehot", 64'(bus.dout_vld), 64'(1 << k));
            chk("route_data", 64'(bus.dout_data[k*DW +: DW]), 64'(route_dat[k]));
            tick();
        end

        // Drop path with all consumers stalled.
        bus.dout_rd = 3'b000;
        tick();
        for (int s = 3; s < 8; s++) send(s, 8'(8'hD0 + s));
        @(negedge clk);
        chk("drop_total", 64'(bus.drop_cnt), 64'd5);
        chk("drop_saturated", 64'(bus2.drop_cnt), 64'd3);
        chk("drop_no_lane", 64'(bus.dout_vld), 64'd0);
        tick();

        // Backpressure on lane 2.
        send(LANE_C, 8'h44);
        bus.din_sel  = SW'(LANE_C);
        bus.din_data = 8'h55;
        bus.din_vld  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_rd", 64'(bus.din_rd), 64'd0);
            chk("bp_hold", 64'(bus.dout_data[LANE_C*DW +: DW]), 64'h44);
        end
        tick();
        bus.dout_rd = 3'b100;
        @(negedge clk);
        chk("bp_release_rd", 64'(bus.din_rd), 64'd1);
        tick();
        bus.din_vld = 1'b0;
        @(negedge clk);
        chk("bp_new_data", 64'(bus.dout_data[LANE_C*DW +: DW]), 64'h55);
        tick();
        send(LANE_A, 8'h66);
        bus.dout_rd = 3'b111;
        repeat (3) tick();

        // Full-rate streaming on lane 1.
        bus.dout_rd = 3'b010;
        for (int k = 0; k < 64; k++) begin
            bus.din_sel  = SW'(LANE_B);
            bus.din_data = 8'(k * 3 + 1);
            bus.din_vld  = 1'b1;
            @(negedge clk);
            chk("stream_rd", 64'(bus.din_rd), 64'd1);
            tick();
        end
        bus.din_vld = 1'b0;
        bus.dout_rd = 3'b111;
        repeat (3) tick();

        // Random traffic against the scoreboard.
        for (int k = 0; k < 10000; k++) begin
            bus.din_vld  = 1'($urandom_range(0, 1));
            bus.din_sel  = SW'($urandom_range(0, 7));
            bus.din_data = 8'($urandom_range(0, 255));
            bus.dout_rd  = 3'($urandom_range(0, 7));
            tick();
        end
        bus.din_vld = 1'b0;
        bus.dout_rd = 3'b111;
        repeat (4) tick();
        @(negedge clk);
        chk("final_vld", 64'(bus.dout_vld), 64'd0);
        for (int i = 0; i < NO; i++) chk($sformatf("final_q%0d_left", i), 64'(exp_q[i].size()), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
